// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared mixer state type, mix-mode codes and arithmetic helpers
// Purpose: common definitions imported by voice_mixer and its sub-modules.
// Ports: none (package).
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } mixer_state_t;

  // Mode code 3 is not listed here; it falls through to the fixed-shift path.
  localparam logic [1:0] MIX_FIXED     = 2'd0;
  localparam logic [1:0] MIX_NORMALISE = 2'd1;
  localparam logic [1:0] MIX_SATURATE  = 2'd2;

  // Unsigned midpoint of a sample of the given width.
  function automatic int unsigned midpoint(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // ceil(log2(n)); 0 and 1 both give 0.
  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if ((32'd1 << i) >= n) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_gain_ramp.sv
// rtl/voice_gain_ramp.sv - per-voice click-free gain envelope
// Purpose: on each tick, moves the gain toward the velocity (note held) or toward
//   zero (note released) by at most RAMP_STEP.
// Ports: i_clk, i_rst_n (async, active-low), i_tick (one-cycle update strobe),
//   i_on (note held), i_vel (target gain), o_gain (current gain).
module voice_gain_ramp #(
  parameter int VEL_W     = 7,
  parameter int RAMP_STEP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_on,
  input  logic [VEL_W-1:0] i_vel,
  output logic [VEL_W-1:0] o_gain
);

  // One extra bit so the upward step cannot wrap before it is clamped.
  localparam logic [VEL_W:0] STEP = (VEL_W + 1)'(RAMP_STEP);

  logic [VEL_W-1:0] r_gain;
  logic [VEL_W-1:0] w_next;
  logic [VEL_W:0]   w_up;
  logic [VEL_W:0]   w_gain_ext;
  logic [VEL_W:0]   w_vel_ext;

  assign w_gain_ext = {1'b0, r_gain};
  assign w_vel_ext  = {1'b0, i_vel};
  assign w_up       = w_gain_ext + STEP;

  always_comb begin
    w_next = r_gain;
    if (i_on) begin
      // A retrigger at a lower velocity ramps down rather than jumping.
      if (r_gain < i_vel) begin
        w_next = (w_up > w_vel_ext) ? i_vel : w_up[VEL_W-1:0];
      end else if (r_gain > i_vel) begin
        w_next = ((w_gain_ext - w_vel_ext) > STEP) ? VEL_W'(w_gain_ext - STEP) : i_vel;
      end
    end else begin
      w_next = (w_gain_ext > STEP) ? VEL_W'(w_gain_ext - STEP) : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gain <= '0;
    end else if (i_tick) begin
      r_gain <= w_next;
    end
  end

  assign o_gain = r_gain;

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - N-voice serial mixer with gain ramps, mode scaling and saturation
// Purpose: every TICK_DIV cycles snapshots the voice inputs, ramps per-voice gains,
//   multiply-accumulates one voice per cycle, scales by mode and saturates to OUT_W.
// Ports: clk_in, rst_n_in (async, active-low); voice_sample_in / voice_on_in /
//   voice_vel_in per-voice inputs; mode_in mix mode; pwm_data_out mixed sample;
//   pwm_data_ready_out one-cycle update pulse; clip_out saturation flag;
//   active_count_out voices with nonzero gain; busy_out high while mixing.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 5,
  parameter int SAMPLE_W    = 8,
  parameter int VEL_W       = 7,
  parameter int OUT_W       = 8,
  parameter int TICK_DIV    = 4536,
  parameter int RAMP_STEP   = 4,
  parameter int FIXED_SHIFT = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  voice_sample_in,
  input  logic [NUM_VOICES-1:0]                voice_on_in,
  input  logic [NUM_VOICES-1:0][VEL_W-1:0]     voice_vel_in,
  input  logic [1:0]                           mode_in,
  output logic [OUT_W-1:0]                     pwm_data_out,
  output logic                                 pwm_data_ready_out,
  output logic                                 clip_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]      active_count_out,
  output logic                                 busy_out
);

  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam int IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACT_W    = $clog2(NUM_VOICES + 1);
  localparam int PROD_W   = SAMPLE_W + VEL_W + 1;
  localparam int ACC_W    = SAMPLE_W + VEL_W + $clog2(NUM_VOICES) + 1;
  localparam int ALIGN_UP = (OUT_W >= SAMPLE_W) ? OUT_W - SAMPLE_W : 0;
  localparam int ALIGN_DN = (OUT_W >= SAMPLE_W) ? 0 : SAMPLE_W - OUT_W;

  localparam logic signed [SAMPLE_W:0] MID_IN  = (SAMPLE_W + 1)'(midpoint(SAMPLE_W));
  localparam logic signed [ACC_W+1:0]  MID_OUT = (ACC_W + 2)'(midpoint(OUT_W));
  localparam logic signed [ACC_W+1:0]  MAX_OUT = (ACC_W + 2)'((64'd1 << OUT_W) - 64'd1);

  mixer_state_t r_state, w_state_next;

  logic [CNT_W-1:0]                    r_tick_cnt;
  logic [IDX_W-1:0]                    r_idx;
  logic signed [ACC_W-1:0]             r_acc;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] r_samp;
  logic [1:0]                          r_mode;
  logic [OUT_W-1:0]                    r_mix;
  logic                                r_mix_clip;
  logic [OUT_W-1:0]                    r_pwm;
  logic                                r_ready;
  logic                                r_clip;
  logic [ACT_W-1:0]                    r_active;

  logic                                w_wrap;
  logic [NUM_VOICES-1:0][VEL_W-1:0]    w_gain;
  logic [ACT_W-1:0]                    w_active;
  logic signed [SAMPLE_W:0]            w_c;
  logic signed [PROD_W-1:0]            w_prod;
  logic signed [ACC_W-1:0]             w_s;
  logic signed [ACC_W+1:0]             w_sum;
  logic [OUT_W-1:0]                    w_mix;
  logic                                w_clip;

  assign w_wrap = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

  // Gains advance on the same edge that snapshots the samples, so the whole
  // ACCUM pass sees one consistent set of gains.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_ramp
    voice_gain_ramp #(
      .VEL_W     (VEL_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
      .i_clk   (clk_in),
      .i_rst_n (rst_n_in),
      .i_tick  (w_wrap),
      .i_on    (voice_on_in[gi]),
      .i_vel   (voice_vel_in[gi]),
      .o_gain  (w_gain[gi])
    );
  end

  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_active = w_active + ACT_W'(w_gain[i] != '0);
    end
  end

  // Serial MAC operand: centred sample times gain of the voice selected by r_idx.
  assign w_c    = $signed({1'b0, r_samp[r_idx]}) - MID_IN;
  assign w_prod = PROD_W'(w_c) * PROD_W'($signed({1'b0, w_gain[r_idx]}));

  always_comb begin
    w_s = r_acc >>> VEL_W;
    case (r_mode)
      MIX_NORMALISE: w_s = w_s >>> ceil_log2(32'(w_active));
      MIX_SATURATE:  w_s = w_s;
      default:       w_s = w_s >>> FIXED_SHIFT;
    endcase
    w_s   = (w_s <<< ALIGN_UP) >>> ALIGN_DN;
    w_sum = (ACC_W + 2)'(w_s) + MID_OUT;
    w_mix  = w_sum[OUT_W-1:0];
    w_clip = 1'b0;
    if (w_sum < 0) begin
      w_mix  = '0;
      w_clip = 1'b1;
    end else if (w_sum > MAX_OUT) begin
      w_mix  = '1;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_wrap) w_state_next = ACCUM;
      ACCUM:   if (r_idx == IDX_W'(NUM_VOICES - 1)) w_state_next = SCALE;
      SCALE:   w_state_next = OUTPUT;
      OUTPUT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick_cnt <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_samp     <= '0;
      r_mode     <= MIX_FIXED;
      r_mix      <= OUT_W'(midpoint(OUT_W));
      r_mix_clip <= 1'b0;
      r_pwm      <= OUT_W'(midpoint(OUT_W));
      r_ready    <= 1'b0;
      r_clip     <= 1'b0;
      r_active   <= '0;
    end else begin
      r_ready    <= 1'b0;
      r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + CNT_W'(1);
      if (r_state == IDLE && w_wrap) begin
        r_samp <= voice_sample_in;
        r_mode <= mode_in;
        r_acc  <= '0;
        r_idx  <= '0;
      end
      if (r_state == ACCUM) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        r_idx <= r_idx + IDX_W'(1);
      end
      if (r_state == SCALE) begin
        r_mix      <= w_mix;
        r_mix_clip <= w_clip;
      end
      if (r_state == OUTPUT) begin
        r_pwm    <= r_mix;
        r_clip   <= r_mix_clip;
        r_active <= w_active;
        r_ready  <= 1'b1;
      end
    end
  end

  assign pwm_data_out       = r_pwm;
  assign pwm_data_ready_out = r_ready;
  assign clip_out           = r_clip;
  assign active_count_out   = r_active;
  assign busy_out           = (r_state != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - self-checking bench for voice_mixer
module tb_voice_mixer;

  localparam int NV = 5;
  localparam int SW = 8;
  localparam int VW = 7;
  localparam int OW = 8;
  localparam int TD = 16;
  localparam int LAT = NV + 2;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in = 1'b1;
  logic [NV-1:0][SW-1:0] voice_sample_in;
  logic [NV-1:0]         voice_on_in;
  logic [NV-1:0][VW-1:0] voice_vel_in;
  logic [1:0]            mode_in;
  logic [OW-1:0]         pwm_data_out;
  logic                  pwm_data_ready_out;
  logic                  clip_out;
  logic [2:0]            active_count_out;
  logic                  busy_out;

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int gain [NV];
  int exp_out, exp_clip, exp_act;

  voice_mixer #(.TICK_DIV(TD)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .voice_sample_in    (voice_sample_in),
    .voice_on_in        (voice_on_in),
    .voice_vel_in       (voice_vel_in),
    .mode_in            (mode_in),
    .pwm_data_out       (pwm_data_out),
    .pwm_data_ready_out (pwm_data_ready_out),
    .clip_out           (clip_out),
    .active_count_out   (active_count_out),
    .busy_out           (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Clock edges since reset release; edge k (k % TD == 0) is a snapshot edge.
  always @(posedge clk_in) begin
    if (!rst_n_in) edges <= 0;
    else           edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Applies the gain rules to the current inputs, then mixes them with plain arithmetic.
  function automatic void model_snapshot();
    int acc, s, sh, n, v;
    acc = 0;
    n = 0;
    for (int i = 0; i < NV; i++) begin
      v = int'(voice_vel_in[i]);
      if (voice_on_in[i]) begin
        if (gain[i] < v) gain[i] = (gain[i] + 4 > v) ? v : gain[i] + 4;
        else             gain[i] = (gain[i] - 4 < v) ? v : gain[i] - 4;
      end else begin
        gain[i] = (gain[i] > 4) ? gain[i] - 4 : 0;
      end
      if (gain[i] != 0) n++;
      acc += (int'(voice_sample_in[i]) - 128) * gain[i];
    end
    s = floor_div(acc, 128);
    if (mode_in == 2'd2) sh = 0;
    else if (mode_in == 2'd1) begin
      sh = 0;
      while ((1 << sh) < n) sh++;
    end else sh = 2;
    s = floor_div(s, 1 << sh) + 128;
    exp_clip = (s < 0 || s > 255) ? 1 : 0;
    exp_out  = (s < 0) ? 0 : (s > 255) ? 255 : s;
    exp_act  = n;
  endfunction

  task automatic wait_wrap(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk_in);
      guard++;
    end while ((edges % TD != 0) && guard < 40);
    check({tag, "/wrap_found"}, 32'(guard < 40), 32'd1);
  endtask

  // One sample period: snapshot, scrambled inputs during ACCUM, latency and result checks.
  task automatic run_tick(input string tag);
    logic [NV-1:0][SW-1:0] s_samp;
    logic [NV-1:0]         s_on;
    logic [NV-1:0][VW-1:0] s_vel;
    logic [1:0]            s_mode;
    wait_wrap(tag);
    model_snapshot();
    s_samp = voice_sample_in; s_on = voice_on_in; s_vel = voice_vel_in; s_mode = mode_in;
    for (int i = 0; i < NV; i++) begin
      voice_sample_in[i] = SW'($urandom);
      voice_vel_in[i]    = VW'($urandom);
    end
    voice_on_in = NV'($urandom);
    mode_in     = 2'($urandom);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk_in);
      check({tag, "/ready_early"}, 32'(pwm_data_ready_out), 32'd0);
      if (k == 1) check({tag, "/busy"}, 32'(busy_out), 32'd1);
    end
    voice_sample_in = s_samp; voice_on_in = s_on; voice_vel_in = s_vel; mode_in = s_mode;
    @(negedge clk_in);
    check({tag, "/ready"}, 32'(pwm_data_ready_out), 32'd1);
    check({tag, "/busy_idle"}, 32'(busy_out), 32'd0);
    check({tag, "/out"}, 32'(pwm_data_out), exp_out);
    check({tag, "/clip"}, 32'(clip_out), exp_clip);
    check({tag, "/active"}, 32'(active_count_out), exp_act);
    @(negedge clk_in);
    check({tag, "/ready_pulse"}, 32'(pwm_data_ready_out), 32'd0);
  endtask

  task automatic set_voices(input logic [NV-1:0] on, input int vel, input int samp);
    for (int i = 0; i < NV; i++) begin
      voice_on_in[i]     = on[i];
      voice_vel_in[i]    = VW'(vel);
      voice_sample_in[i] = SW'(samp);
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < NV; i++) gain[i] = 0;
    set_voices('0, 0, 128);
    mode_in = 2'd2;

    // Asynchronous reset, no clock edge yet.
    #1 rst_n_in = 1'b0;
    #1;
    check("rst/out", 32'(pwm_data_out), 32'd128);
    check("rst/ready", 32'(pwm_data_ready_out), 32'd0);
    check("rst/clip", 32'(clip_out), 32'd0);
    check("rst/active", 32'(active_count_out), 32'd0);
    check("rst/busy", 32'(busy_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    // Single voice ramp.
    set_voices(5'b00001, 127, 255);
    voice_sample_in[1] = 8'd0;
    mode_in = 2'd2;
    for (int t = 0; t < 32; t++) run_tick("ramp1");
    check("ramp1/final_out", 32'(pwm_data_out), 32'd254);
    check("ramp1/final_clip", 32'(clip_out), 32'd0);
    check("ramp1/final_active", 32'(active_count_out), 32'd1);

    // Four voices: saturate, then normalise.
    set_voices(5'b01111, 127, 255);
    for (int t = 0; t < 32; t++) run_tick("four_sat");
    check("four_sat/final_out", 32'(pwm_data_out), 32'd255);
    check("four_sat/final_clip", 32'(clip_out), 32'd1);
    mode_in = 2'd1;
    run_tick("four_norm");
    check("four_norm/final_out", 32'(pwm_data_out), 32'd254);
    check("four_norm/final_clip", 32'(clip_out), 32'd0);

    // Reset dropped mid-ACCUM: outputs return at once and that sample never completes.
    wait_wrap("midrst");
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("midrst/out", 32'(pwm_data_out), 32'd128);
    check("midrst/ready", 32'(pwm_data_ready_out), 32'd0);
    check("midrst/clip", 32'(clip_out), 32'd0);
    check("midrst/active", 32'(active_count_out), 32'd0);
    check("midrst/busy", 32'(busy_out), 32'd0);
    for (int i = 0; i < NV; i++) gain[i] = 0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    seen = 0;
    for (int k = 0; k < TD - 1; k++) begin
      @(negedge clk_in);
      if (pwm_data_ready_out !== 1'b0) seen++;
    end
    check("midrst/no_pulse", 32'(seen), 32'd0);
    run_tick("midrst_after");

    // Randomised voices, velocities, samples and modes.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NV; i++) begin
        voice_on_in[i]  = 1'($urandom);
        voice_vel_in[i] = VW'($urandom);
        case ($urandom_range(0, 2))
          0:       voice_sample_in[i] = 8'd0;
          1:       voice_sample_in[i] = 8'd255;
          default: voice_sample_in[i] = SW'($urandom);
        endcase
      end
      mode_in = 2'($urandom);
      run_tick("rand");
    end

    // Voice 0 steady, then released: decays to the midpoint.
    set_voices(5'b00001, 127, 255);
    for (int i = 1; i < NV; i++) voice_sample_in[i] = SW'($urandom);
    mode_in = 2'd2;
    for (int t = 0; t < 32; t++) run_tick("steady");
    check("steady/out", 32'(pwm_data_out), 32'd254);
    check("steady/active", 32'(active_count_out), 32'd1);
    voice_on_in = '0;
    for (int t = 0; t < 31; t++) run_tick("release");
    check("release/tail_out", 32'(pwm_data_out), 32'd130);
    check("release/tail_active", 32'(active_count_out), 32'd1);
    run_tick("release_end");
    check("release/final_out", 32'(pwm_data_out), 32'd128);
    check("release/final_active", 32'(active_count_out), 32'd0);
    check("release/final_clip", 32'(clip_out), 32'd0);
    run_tick("silent");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
